// File: rtl/wb_timer.sv
// wb_timer: Wishbone B3 classic slave timer for the nanorv32 SoC.
// 32-bit up-counter with prescaler, compare match flag and level interrupt.
// Register map (adr[3:2]): 0 CTRL, 1 COUNT, 2 COMPARE, 3 STATUS.
// Build option: define WB_TIMER_PRESCALER_EN to include the prescaler;
// without it the counter ticks every cycle while EN=1 and PRESCALE reads 0.
module wb_timer #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        irq_o
);

  localparam logic [1:0] ADR_CTRL    = 2'd0;
  localparam logic [1:0] ADR_COUNT   = 2'd1;
  localparam logic [1:0] ADR_COMPARE = 2'd2;
  localparam logic [1:0] ADR_STATUS  = 2'd3;

  logic        ctrl_en;
  logic        ctrl_autoreload;
  logic        ctrl_irq_en;
  logic [31:0] count;
  logic [31:0] compare;
  logic        match;
  logic        irq_q;
  logic        tick;

  logic        accept;
  logic        wr_ctrl;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic [31:0] ctrl_rd;
  logic [31:0] ctrl_wr;
  logic [31:0] rd_mux;
  logic [31:0] next_count;
  logic        hit;

  logic [PRESCALE_WIDTH-1:0] prescale;

  // cti/bte are ignored (every access is classic); only adr[3:2] decodes.
  wire unused_inputs = &{1'b0, wb_cti_i, wb_bte_i, wb_adr_i[31:4], wb_adr_i[1:0], ctrl_wr};

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  // The ack register gates acceptance so a held strobe is acked every other cycle.
  assign accept     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_ctrl    = accept & wb_we_i & (wb_adr_i[3:2] == ADR_CTRL);
  assign wr_count   = accept & wb_we_i & (wb_adr_i[3:2] == ADR_COUNT);
  assign wr_compare = accept & wb_we_i & (wb_adr_i[3:2] == ADR_COMPARE);
  assign wr_status  = accept & wb_we_i & (wb_adr_i[3:2] == ADR_STATUS);

  assign next_count = count + 32'd1;
  assign hit        = tick & (next_count == compare);
  assign ctrl_wr    = byte_merge(ctrl_rd, wb_dat_i, wb_sel_i);

  assign wb_err_o   = 1'b0;
  assign irq_o      = irq_q;

  // Assemble the CTRL read view; unimplemented bits read as zero.
  always_comb begin
    ctrl_rd                          = '0;
    ctrl_rd[0]                       = ctrl_en;
    ctrl_rd[1]                       = ctrl_autoreload;
    ctrl_rd[2]                       = ctrl_irq_en;
    ctrl_rd[16 +: PRESCALE_WIDTH]    = prescale;
  end

`ifdef WB_TIMER_PRESCALER_EN
  logic [PRESCALE_WIDTH-1:0] pre_cnt;

  assign tick = ctrl_en & (pre_cnt == prescale);

  // Prescale reload field and counter; any CTRL write restarts the prescale phase.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      prescale <= '0;
      pre_cnt  <= '0;
    end else begin
      if (wr_ctrl) prescale <= ctrl_wr[16 +: PRESCALE_WIDTH];
      if (wr_ctrl || !ctrl_en || tick) pre_cnt <= '0;
      else                             pre_cnt <= pre_cnt + 1'b1;
    end
  end
`else
  assign prescale = '0;
  assign tick     = ctrl_en;
`endif

  // CTRL mode bits.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ctrl_en         <= 1'b0;
      ctrl_autoreload <= 1'b0;
      ctrl_irq_en     <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_en         <= ctrl_wr[0];
      ctrl_autoreload <= ctrl_wr[1];
      ctrl_irq_en     <= ctrl_wr[2];
    end
  end

  // Counter, compare and match flag; a bus write to COUNT overrides the tick.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      count   <= '0;
      compare <= '1;
      match   <= 1'b0;
    end else begin
      if (wr_count)  count <= byte_merge(count, wb_dat_i, wb_sel_i);
      else if (tick) count <= (hit && ctrl_autoreload) ? 32'd0 : next_count;

      if (wr_compare) compare <= byte_merge(compare, wb_dat_i, wb_sel_i);

      // A match set in the same cycle as a W1C keeps the flag set.
      if (hit)                                        match <= 1'b1;
      else if (wr_status && wb_sel_i[0] && wb_dat_i[0]) match <= 1'b0;
    end
  end

  // Interrupt is registered from state only, so no bus-to-irq combinational path.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) irq_q <= 1'b0;
    else          irq_q <= match & ctrl_irq_en;
  end

  // Read data select; reflects register contents before this edge's update.
  always_comb begin
    rd_mux = '0;
    case (wb_adr_i[3:2])
      ADR_CTRL:    rd_mux = ctrl_rd;
      ADR_COUNT:   rd_mux = count;
      ADR_COMPARE: rd_mux = compare;
      ADR_STATUS:  rd_mux = {31'd0, match};
      default:     rd_mux = '0;
    endcase
  end

  // Single-cycle registered acknowledge with read data captured on accept.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= accept;
      if (accept) wb_dat_o <= rd_mux;
    end
  end

endmodule

// File: tb/tb_wb_timer.sv
// Directed self-checking bench for wb_timer. Expected values are hand-computed
// from the register and tick timing; prescale expectations depend on whether
// WB_TIMER_PRESCALER_EN is defined for the build.
module tb_wb_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] rdat;
  logic        ack;
  logic        err;
  logic        irq;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] R_CTRL = 2'd0, R_COUNT = 2'd1, R_COMPARE = 2'd2, R_STATUS = 2'd3;

  wb_timer #(.PRESCALE_WIDTH(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_adr_i (adr),
    .wb_dat_i (wdat),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_cti_i (cti),
    .wb_bte_i (bte),
    .wb_dat_o (rdat),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One classic access: accepted on the first rising edge, ack checked high
  // for exactly one cycle.
  task automatic bus(input logic w, input logic [1:0] r, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] q);
    @(negedge clk);
    adr  = {28'd0, r, 2'b00};
    wdat = d;
    sel  = s;
    we   = w;
    cyc  = 1'b1;
    stb  = 1'b1;
    @(posedge clk);
    #1;
    check("ack_high", {31'd0, ack}, 32'd1);
    q   = rdat;
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
    @(posedge clk);
    #1;
    check("ack_single", {31'd0, ack}, 32'd0);
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] q;
    bus(1'b1, r, d, s, q);
  endtask

  task automatic rd(input logic [1:0] r, input logic [31:0] exp, input string tag);
    logic [31:0] q;
    bus(1'b0, r, 32'd0, 4'hF, q);
    check(tag, q, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; adr = '0; wdat = '0; sel = '0; we = 1'b0;
    cyc = 1'b0; stb = 1'b0; cti = 3'd0; bte = 2'd0;
    idle(3);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", rdat, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;

    // reset values
    rd(R_CTRL,    32'h0000_0000, "reset_ctrl");
    rd(R_COUNT,   32'h0000_0000, "reset_count");
    rd(R_COMPARE, 32'hFFFF_FFFF, "reset_compare");
    rd(R_STATUS,  32'h0000_0000, "reset_status");
    check("reset_irq", {31'd0, irq}, 32'd0);

    // prescale: CTRL ack edge E; reads accepted at E+20 and E+22
    wr(R_COUNT, 32'd0, 4'hF);
    wr(R_CTRL, 32'h0003_0001, 4'hF);
    idle(18);
`ifdef WB_TIMER_PRESCALER_EN
    rd(R_COUNT, 32'd4, "prescale_e19");
    rd(R_COUNT, 32'd5, "prescale_e21");
    rd(R_CTRL,  32'h0003_0001, "prescale_ctrl");
`else
    rd(R_COUNT, 32'd19, "prescale_e19");
    rd(R_COUNT, 32'd21, "prescale_e21");
    rd(R_CTRL,  32'h0000_0001, "prescale_ctrl");
`endif
    wr(R_CTRL, 32'd0, 4'hF);

    // auto-reload with IRQ, COMPARE=9: match at E+9, E+18, E+27
    wr(R_COUNT, 32'd0, 4'hF);
    wr(R_COMPARE, 32'd9, 4'hF);
    wr(R_CTRL, 32'h0000_0007, 4'hF);
    rd(R_COUNT, 32'd1, "ar_count_1");
    rd(R_COUNT, 32'd3, "ar_count_3");
    rd(R_COUNT, 32'd5, "ar_count_5");
    rd(R_COUNT, 32'd7, "ar_count_7");
    check("ar_irq_before", {31'd0, irq}, 32'd0);
    rd(R_COUNT, 32'd0, "ar_count_reload");
    check("ar_irq_set", {31'd0, irq}, 32'd1);
    rd(R_STATUS, 32'd1, "ar_match");
    wr(R_STATUS, 32'd1, 4'hF);
    check("ar_irq_w1c", {31'd0, irq}, 32'd0);
    rd(R_STATUS, 32'd0, "ar_status_clr_a");
    rd(R_STATUS, 32'd0, "ar_status_clr_b");
    rd(R_STATUS, 32'd1, "ar_second_match");
    check("ar_irq_second", {31'd0, irq}, 32'd1);

    // W1C accepted on the match-set edge E+27: set wins
    idle(5);
    wr(R_STATUS, 32'd1, 4'hF);
    rd(R_STATUS, 32'd1, "w1c_collision");
    check("w1c_collision_irq", {31'd0, irq}, 32'd1);
    wr(R_CTRL, 32'd0, 4'hF);
    check("irq_en_clear", {31'd0, irq}, 32'd0);
    wr(R_STATUS, 32'd1, 4'hF);

    // wrap: 0xFFFF_FFFE -> 0xFFFF_FFFF -> 0 -> ..., match at COUNT=5
    wr(R_COUNT, 32'hFFFF_FFFE, 4'hF);
    wr(R_COMPARE, 32'd5, 4'hF);
    wr(R_CTRL, 32'h0000_0001, 4'hF);
    rd(R_COUNT, 32'hFFFF_FFFF, "wrap_ffff");
    rd(R_COUNT, 32'd1, "wrap_one");
    rd(R_STATUS, 32'd0, "wrap_no_match");
    rd(R_STATUS, 32'd1, "wrap_match");
    rd(R_COUNT, 32'd7, "wrap_no_reload");
    check("wrap_irq_off", {31'd0, irq}, 32'd0);

    // COUNT write in a tick cycle: write wins, one tick later reads 0x101
    wr(R_COUNT, 32'h0000_0100, 4'hF);
    rd(R_COUNT, 32'h0000_0101, "count_write_collision");
    wr(R_CTRL, 32'd0, 4'hF);
    wr(R_STATUS, 32'd1, 4'hF);
    rd(R_STATUS, 32'd0, "status_cleared");

    // byte enables
    wr(R_COMPARE, 32'hFFFF_FFFF, 4'hF);
    wr(R_COMPARE, 32'hAABB_CCDD, 4'b0010);
    rd(R_COMPARE, 32'hFFFF_CCFF, "byte_enable");

    // reset during an access: no ack, registers back to reset values
    @(negedge clk);
    adr = {28'd0, R_COMPARE, 2'b00}; we = 1'b0; sel = 4'hF;
    cyc = 1'b1; stb = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_ack", {31'd0, ack}, 32'd0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    rd(R_COMPARE, 32'hFFFF_FFFF, "rst_mid_compare");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
